// File: rtl/vx_pending_tracker.sv
// Per-warp in-flight instruction tracker: issue/commit counters, issue stalls,
// sticky over/underflow flags and a single-outstanding drain handshake.
module vx_pending_tracker #(
  parameter int NUM_WARPS   = 4,
  parameter int MAX_PENDING = 15,
  parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WARPS-1:0] issue_warps,
  input  logic [NUM_WARPS-1:0] committed_warps,
  input  logic                 drain_valid,
  input  logic [NW_WIDTH-1:0]  drain_wid,
  output logic                 drain_ready,
  output logic                 drain_done,
  output logic [NW_WIDTH-1:0]  drain_done_wid,
  output logic [NUM_WARPS-1:0] pending_warps,
  output logic [NUM_WARPS-1:0] stall_warps,
  output logic                 all_idle,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam int               CTR_W   = $clog2(MAX_PENDING + 1);
  localparam logic [CTR_W-1:0] MAX_CNT = CTR_W'(MAX_PENDING);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  logic [CTR_W-1:0]     counts [NUM_WARPS];
  logic [NUM_WARPS-1:0] full;
  logic [NUM_WARPS-1:0] zero;
  logic [NUM_WARPS-1:0] ovf_hit;
  logic [NUM_WARPS-1:0] unf_hit;

  state_e               state;
  state_e               next_state;
  logic [NW_WIDTH-1:0]  latched_wid;
  logic                 drained;

  // ---------------------------------------------------------------------------
  // Counter status and error detection
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    full    = '0;
    zero    = '0;
    ovf_hit = '0;
    unf_hit = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      full[w]    = (counts[w] == MAX_CNT);
      zero[w]    = (counts[w] == '0);
      ovf_hit[w] = issue_warps[w] && !committed_warps[w] && full[w];
      unf_hit[w] = !issue_warps[w] && committed_warps[w] && zero[w];
    end
  end

  // Simultaneous issue and commit cancel; saturated ends hold their value.
  always_ff @(posedge clk) begin
    // NOTE: the counters are a small register array, not a RAM, so they can and must clear on reset.
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        // NOTE: sequential state uses non-blocking assignments so all warps update from the same pre-edge values.
        counts[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (issue_warps[w] && !committed_warps[w] && !full[w]) begin
          counts[w] <= counts[w] + CTR_W'(1);
        end else if (!issue_warps[w] && committed_warps[w] && !zero[w]) begin
          counts[w] <= counts[w] - CTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= overflow_err  | (|ovf_hit);
      underflow_err <= underflow_err | (|unf_hit);
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM: state register, next-state logic, outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      latched_wid <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && drain_valid) begin
        latched_wid <= drain_wid;
      end
    end
  end

  // Looks at the registered count only, so same-cycle traffic is seen next cycle.
  assign drained = zero[latched_wid];

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (drain_valid) next_state = S_WAIT;
      S_WAIT:  if (drained)     next_state = S_DONE;
      S_DONE:                   next_state = S_IDLE;
      default:                  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    drain_ready    = (state == S_IDLE);
    drain_done     = (state == S_DONE);
    drain_done_wid = (state == S_DONE) ? latched_wid : '0;
  end

  // ---------------------------------------------------------------------------
  // Per-warp status outputs (registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_warps = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      stall_warps[w] = full[w] || ((state != S_IDLE) && (latched_wid == NW_WIDTH'(w)));
    end
  end

  assign pending_warps = ~zero;
  assign all_idle      = (&zero) && (state == S_IDLE);

`ifndef SYNTHESIS
  logic [NW_WIDTH:0] drain_wid_ext;
  assign drain_wid_ext = {1'b0, drain_wid};

  always @(posedge clk) begin
    if (!reset && drain_valid && drain_ready) begin
      assert (drain_wid_ext < (NW_WIDTH + 1)'(NUM_WARPS))
        else $error("drain_wid %0d out of range", drain_wid);
    end
  end
`endif

endmodule

// File: tb/tb_vx_pending_tracker.sv
// Directed bench for vx_pending_tracker: counters, saturation flags, stalls
// and drain handshake timing, all against hand-computed expectations.
module tb_vx_pending_tracker;

  localparam int NUM_WARPS = 4;
  localparam int NW_WIDTH  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_WARPS-1:0] issue_warps;
  logic [NUM_WARPS-1:0] committed_warps;
  logic                 drain_valid;
  logic [NW_WIDTH-1:0]  drain_wid;
  logic                 drain_ready;
  logic                 drain_done;
  logic [NW_WIDTH-1:0]  drain_done_wid;
  logic [NUM_WARPS-1:0] pending_warps;
  logic [NUM_WARPS-1:0] stall_warps;
  logic                 all_idle;
  logic                 overflow_err;
  logic                 underflow_err;

  int n_checks = 0;
  int n_pass   = 0;
  int done_pulses;

  vx_pending_tracker #(.NUM_WARPS(NUM_WARPS), .MAX_PENDING(15)) dut (
    .clk             (clk),
    .reset           (reset),
    .issue_warps     (issue_warps),
    .committed_warps (committed_warps),
    .drain_valid     (drain_valid),
    .drain_wid       (drain_wid),
    .drain_ready     (drain_ready),
    .drain_done      (drain_done),
    .drain_done_wid  (drain_done_wid),
    .pending_warps   (pending_warps),
    .stall_warps     (stall_warps),
    .all_idle        (all_idle),
    .overflow_err    (overflow_err),
    .underflow_err   (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one cycle; inputs driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    issue_warps = '0;
    committed_warps = '0;
    drain_valid = 1'b0;
    drain_wid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},    32'(drain_ready),    32'd1);
    check({tag, "_done"},     32'(drain_done),     32'd0);
    check({tag, "_done_wid"}, 32'(drain_done_wid), 32'd0);
    check({tag, "_pending"},  32'(pending_warps),  32'd0);
    check({tag, "_stall"},    32'(stall_warps),    32'd0);
    check({tag, "_all_idle"}, 32'(all_idle),       32'd1);
    check({tag, "_ovf"},      32'(overflow_err),   32'd0);
    check({tag, "_unf"},      32'(underflow_err),  32'd0);
  endtask

  initial begin
    // Reset then idle three cycles.
    do_reset();
    tick(); tick(); tick();
    check_idle_outputs("rst");

    // Warp 2: three issues then three commits.
    for (int i = 0; i < 3; i++) begin
      issue_warps = 4'b0100;
      tick();
      check("w2_issue_pending", 32'(pending_warps), 32'h4);
    end
    issue_warps = '0;
    for (int i = 0; i < 3; i++) begin
      committed_warps = 4'b0100;
      tick();
      check("w2_commit_pending", 32'(pending_warps), (i < 2) ? 32'h4 : 32'h0);
    end
    committed_warps = '0;
    check("w2_ovf", 32'(overflow_err), 32'd0);
    check("w2_unf", 32'(underflow_err), 32'd0);
    check("w2_all_idle", 32'(all_idle), 32'd1);

    // Warp 0: fill to 15, then overflow, then issue+commit at full.
    for (int i = 0; i < 15; i++) begin
      issue_warps = 4'b0001;
      tick();
      check("w0_fill_stall", 32'(stall_warps), (i == 14) ? 32'h1 : 32'h0);
    end
    check("w0_fill_ovf", 32'(overflow_err), 32'd0);
    tick();
    check("w0_16th_ovf", 32'(overflow_err), 32'd1);
    check("w0_16th_stall", 32'(stall_warps), 32'h1);
    committed_warps = 4'b0001;
    tick();
    check("w0_both_stall", 32'(stall_warps), 32'h1);
    check("w0_both_unf", 32'(underflow_err), 32'd0);
    issue_warps = '0;
    // Count must still be 15: 14 commits leave it pending, the 15th clears it.
    for (int i = 0; i < 15; i++) begin
      tick();
      check("w0_drain_pending", 32'(pending_warps), (i < 14) ? 32'h1 : 32'h0);
    end
    committed_warps = '0;
    check("w0_drain_stall", 32'(stall_warps), 32'h0);
    check("w0_ovf_sticky", 32'(overflow_err), 32'd1);
    check("w0_unf_after", 32'(underflow_err), 32'd0);
    do_reset();
    check("w0_ovf_cleared", 32'(overflow_err), 32'd0);

    // Warp 1: issue+commit at zero, then commit alone at zero.
    issue_warps = 4'b0010;
    committed_warps = 4'b0010;
    tick();
    check("w1_both_pending", 32'(pending_warps), 32'h0);
    check("w1_both_unf", 32'(underflow_err), 32'd0);
    issue_warps = '0;
    tick();
    check("w1_unf_set", 32'(underflow_err), 32'd1);
    committed_warps = '0;
    tick(); tick();
    check("w1_unf_sticky", 32'(underflow_err), 32'd1);
    check("w1_pending", 32'(pending_warps), 32'h0);
    do_reset();

    // Drain warp 0 already at zero: DONE at T+2, ready at T+3.
    drain_valid = 1'b1;
    drain_wid = 2'd0;
    tick();
    drain_valid = 1'b0;
    check("dz_t1_ready", 32'(drain_ready), 32'd0);
    check("dz_t1_done", 32'(drain_done), 32'd0);
    tick();
    check("dz_t2_done", 32'(drain_done), 32'd1);
    check("dz_t2_wid", 32'(drain_done_wid), 32'd0);
    tick();
    check("dz_t3_done", 32'(drain_done), 32'd0);
    check("dz_t3_ready", 32'(drain_ready), 32'd1);

    // Drain warp 3 with count 2, commits in cycles T+4 and T+6.
    issue_warps = 4'b1000;
    tick(); tick();
    issue_warps = '0;
    check("d3_pre_ready", 32'(drain_ready), 32'd1);
    drain_valid = 1'b1;
    drain_wid = 2'd3;
    tick();
    drain_valid = 1'b0;
    done_pulses = 0;
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("d3_t%0d_stall", c), 32'(stall_warps[3]), (c <= 8) ? 32'd1 : 32'd0);
      check($sformatf("d3_t%0d_done", c), 32'(drain_done), (c == 8) ? 32'd1 : 32'd0);
      check($sformatf("d3_t%0d_wid", c), 32'(drain_done_wid), (c == 8) ? 32'd3 : 32'd0);
      check($sformatf("d3_t%0d_ready", c), 32'(drain_ready), (c == 9) ? 32'd1 : 32'd0);
      if (drain_done) done_pulses++;
      committed_warps = (c == 4 || c == 6) ? 4'b1000 : 4'b0000;
      tick();
    end
    committed_warps = '0;
    check("d3_done_pulses", 32'(done_pulses), 32'd1);
    check("d3_unf", 32'(underflow_err), 32'd0);

    // Drain warp 1 (count 1) and reset during WAIT.
    issue_warps = 4'b0010;
    tick();
    issue_warps = '0;
    drain_valid = 1'b1;
    drain_wid = 2'd1;
    tick();
    drain_valid = 1'b0;
    check("rw_wait_ready", 32'(drain_ready), 32'd0);
    check("rw_wait_stall", 32'(stall_warps), 32'h2);
    tick();
    done_pulses = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("rw_post");
    for (int i = 0; i < 4; i++) begin
      if (drain_done) done_pulses++;
      tick();
    end
    check("rw_no_done", 32'(done_pulses), 32'd0);
    check("rw_final_ready", 32'(drain_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vx_pending_tracker.md
Name: vx_pending_tracker

Overview:
- Scheduler-side consumer of the commit-to-scheduler interface.
- Keeps a per-warp count of issued-but-uncommitted instructions:
  - +1 per issue of a warp;
  - −1 per end-of-packet commit pulse (`committed_warps`) for that warp.
- Drives per-warp issue stalls when a warp is at capacity.
- Provides a drain handshake used by fences/barriers: wait until a given warp has zero instructions in flight, then pulse done.

Parameters:
- NUM_WARPS, 4, number of warps tracked; ≥1.
- MAX_PENDING, 15, maximum in-flight instructions per warp; CTR_W = clog2(MAX_PENDING+1).
- NW_WIDTH, clog2(NUM_WARPS) (min 1), warp-id width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- issue_warps  in  NUM_WARPS  one bit per warp; bit w = one instruction of warp w issued this cycle.
- committed_warps  in  NUM_WARPS  one bit per warp; bit w = one instruction of warp w fully committed (eop), already registered by the commit stage.
- drain_valid  in  1  drain request valid.
- drain_wid  in  NW_WIDTH  warp to drain.
- drain_ready  out  1  request accepted when valid&&ready.
- drain_done  out  1  one-cycle pulse: drained warp reached zero pending.
- drain_done_wid  out  NW_WIDTH  warp id that accompanies drain_done.
- pending_warps  out  NUM_WARPS  bit w = count[w] != 0.
- stall_warps  out  NUM_WARPS  bit w = warp w must not issue.
- all_idle  out  1  all counts zero and drain FSM IDLE.
- overflow_err  out  1  sticky: issue while count == MAX_PENDING.
- underflow_err  out  1  sticky: commit while count == 0.

Behaviour:
- Reset: all counts 0; FSM IDLE; sticky errors 0; latched wid 0.
  - Resulting outputs: drain_ready=1, drain_done=0, drain_done_wid=0, pending_warps=0, stall_warps=0, all_idle=1.
- Counter update, per warp w, registered, visible next cycle:
  - inc && !dec: count+1. If count == MAX_PENDING, hold count and set overflow_err.
  - !inc && dec: count−1. If count == 0, hold 0 and set underflow_err.
  - inc && dec: count unchanged, including at 0 and at MAX_PENDING; no error flagged.
  - Multiple warps update independently in the same cycle.
- pending_warps and all_idle are combinational from registered state only; no input-to-output path.
- full[w] = (count[w] == MAX_PENDING).
- stall_warps[w] = full[w] | (state != IDLE && latched_wid == w).
- Drain FSM:
  - IDLE: drain_ready=1. On drain_valid, latch drain_wid and go to WAIT.
  - WAIT: drain_ready=0. When the registered count[latched_wid] == 0, go to DONE. An issue or commit in the same cycle affects only the next cycle's count.
  - DONE: drain_done=1 and drain_done_wid=latched_wid for exactly one cycle; drain_ready=0; next state IDLE.
- Drain latency:
  - Request accepted at cycle T with that warp already at zero: DONE at T+2, IDLE at T+3.
  - Back-to-back requests are accepted no earlier than T+3.
- If the upstream issues to the drained warp despite the stall, the count still increments. WAIT simply extends until the count returns to zero.
- Reset mid-drain: FSM returns to IDLE immediately and no drain_done is emitted.
- drain_wid ≥ NUM_WARPS is illegal; debug builds carry an assertion for it.

Test Plan:
- Reset, then idle 3 cycles -> all_idle=1, drain_ready=1, all outputs otherwise 0.
- Warp 2: issue ×3 on consecutive cycles, then commit ×3 -> pending_warps=4'b0100 from cycle 1 until 1 cycle after the last commit, then 0; no error flags.
- Warp 0, MAX_PENDING=15: issue ×15 -> stall_warps[0]=1. A 16th issue sets overflow_err=1 and count stays 15. Simultaneous issue+commit at 15 -> count 15, no change to flags.
- Warp 1: with count=0, assert both issue and commit in the same cycle -> count stays 0, underflow_err=0. A commit alone at 0 -> underflow_err=1 (sticky).
- Drain warp 3 with count=2, commits arriving at T+4 and T+6 -> stall_warps[3]=1 from T+1. drain_done=1 with drain_done_wid=3 exactly once, 2 cycles after the last commit (T+8). drain_ready re-asserts at T+9.
- Drain warp 1 (count 1), assert reset during WAIT -> no drain_done pulse; all outputs at reset values the cycle after reset.
